csr_file_mh: RTL and testbench

- Per-hart machine-mode CSR file, successor to the single-view CSR block. Parametrised in hart count and counter width.
- Adds csrrw/csrrs/csrrc semantics, MPIE save/restore, mscratch, per-hart external and timer interrupt pending with a registered interrupt request, and 64-bit mcycle/minstret counters.
- Sits beside the barrel-threaded pipeline's decode/execute stage. The trap unit drives trap/mret events; the fetch unit consumes mtvec/mepc and irq_req.

---
 rtl/csr_file_mh_if.sv | 29 ++
 rtl/csr_file_mh.sv | 214 +++++++++++++++++++++
 tb/tb_csr_file_mh.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_file_mh_if.sv
`default_nettype none
// ============================================================================
// Module : csr_file_mh_if
// CSR access bus between the decode/execute stage and the per-hart CSR file.
// Rev    : 1.0
// ============================================================================
interface csr_file_mh_if #(
    parameter int HART_ID_W = 2,
    parameter int XLEN      = 32
);
    logic [HART_ID_W-1:0] hart_id;
    logic [11:0]          csr_addr;
    logic [1:0]           csr_op;
    logic [XLEN-1:0]      csr_wdata;
    logic                 csr_re;
    logic [XLEN-1:0]      csr_rdata;
    logic                 csr_illegal;

    modport master (
        output hart_id, csr_addr, csr_op, csr_wdata, csr_re,
        input  csr_rdata, csr_illegal
    );

    modport slave (
        input  hart_id, csr_addr, csr_op, csr_wdata, csr_re,
        output csr_rdata, csr_illegal
    );
endinterface
`default_nettype wire

// File: rtl/csr_file_mh.sv
`default_nettype none
// ============================================================================
// Module : csr_file_mh
// Per-hart machine-mode CSR file with shared mcycle and per-hart minstret.
// Rev    : 1.0
// ============================================================================
module csr_file_mh #(
    parameter int HART_NUM  = 4,
    parameter int HART_ID_W = 2,
    parameter int XLEN      = 32,
    parameter int CNT_W     = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    csr_file_mh_if.slave         csr,
    input  logic [HART_NUM-1:0]  ext_irq,
    input  logic [HART_NUM-1:0]  timer_irq,
    input  logic                 trap_set,
    input  logic [HART_ID_W-1:0] trap_hart_id,
    input  logic [XLEN-1:0]      trap_mepc,
    input  logic [XLEN-1:0]      trap_mcause,
    input  logic                 mret_set,
    input  logic [HART_ID_W-1:0] mret_hart_id,
    input  logic [HART_NUM-1:0]  instret_inc,
    output logic [HART_NUM-1:0]  irq_req,
    output logic [XLEN-1:0]      irq_cause_o,
    output logic [XLEN-1:0]      mstatus_o,
    output logic [XLEN-1:0]      mie_o,
    output logic [XLEN-1:0]      mip_o,
    output logic [XLEN-1:0]      mtvec_o,
    output logic [XLEN-1:0]      mepc_o,
    output logic [XLEN-1:0]      mcause_o
);
    localparam int          HI_W        = CNT_W - 32;
    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_MHARTID   = 12'hF14;

    logic [HART_NUM-1:0] mie_bit, mpie_bit, meie, mtie, meip, mtip;
    logic [XLEN-1:0]     mtvec    [HART_NUM];
    logic [XLEN-1:0]     mscratch [HART_NUM];
    logic [XLEN-1:0]     mepc     [HART_NUM];
    logic [XLEN-1:0]     mcause   [HART_NUM];
    logic [CNT_W-1:0]    minstret [HART_NUM];
    logic [CNT_W-1:0]    mcycle;

    logic [HART_ID_W-1:0] hid;
    logic [XLEN-1:0]      mstatus_v, mie_v, mip_v, old_val, new_val;
    logic                 implemented, read_only;
    logic [HART_NUM-1:0]  trap_hit, mret_hit, csr_hit;

    assign hid = csr.hart_id;

    always_comb begin
        mstatus_v        = '0;
        mstatus_v[12:11] = 2'b11;
        mstatus_v[7]     = mpie_bit[hid];
        mstatus_v[3]     = mie_bit[hid];
        mie_v            = '0;
        mie_v[11]        = meie[hid];
        mie_v[7]         = mtie[hid];
        mip_v            = '0;
        mip_v[11]        = meip[hid];
        mip_v[7]         = mtip[hid];
    end

    always_comb begin
        old_val     = '0;
        implemented = 1'b1;
        read_only   = 1'b0;
        case (csr.csr_addr)
            A_MSTATUS:   old_val = mstatus_v;
            A_MIE:       old_val = mie_v;
            A_MTVEC:     old_val = mtvec[hid];
            A_MSCRATCH:  old_val = mscratch[hid];
            A_MEPC:      old_val = mepc[hid];
            A_MCAUSE:    old_val = mcause[hid];
            A_MCYCLE:    old_val = mcycle[31:0];
            A_MCYCLEH:   old_val = XLEN'(mcycle[CNT_W-1:32]);
            A_MINSTRET:  old_val = minstret[hid][31:0];
            A_MINSTRETH: old_val = XLEN'(minstret[hid][CNT_W-1:32]);
            A_MIP: begin
                old_val   = mip_v;
                read_only = 1'b1;
            end
            A_MHARTID: begin
                old_val   = XLEN'(hid);
                read_only = 1'b1;
            end
            default:     implemented = 1'b0;
        endcase
    end

    always_comb begin
        case (csr.csr_op)
            2'b01:   new_val = csr.csr_wdata;
            2'b10:   new_val = old_val | csr.csr_wdata;
            2'b11:   new_val = old_val & ~csr.csr_wdata;
            default: new_val = old_val;
        endcase
    end

    assign csr.csr_rdata   = old_val;
    assign csr.csr_illegal = (csr.csr_re | (csr.csr_op != 2'b00))
                           & (~implemented | ((csr.csr_op != 2'b00) & read_only));

    // Per-hart arbitration: trap beats mret beats the CSR op; losers are dropped.
    always_comb begin
        trap_hit = '0;
        mret_hit = '0;
        csr_hit  = '0;
        for (int h = 0; h < HART_NUM; h++) begin
            trap_hit[h] = trap_set && (trap_hart_id == HART_ID_W'(h));
            mret_hit[h] = mret_set && (mret_hart_id == HART_ID_W'(h)) && !trap_hit[h];
            csr_hit[h]  = (csr.csr_op != 2'b00) && implemented && !read_only
                        && (hid == HART_ID_W'(h)) && !trap_hit[h] && !mret_hit[h];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mie_bit  <= '0;
            mpie_bit <= '0;
            meie     <= '0;
            mtie     <= '0;
            meip     <= '0;
            mtip     <= '0;
            irq_req  <= '0;
            mcycle   <= '0;
            for (int h = 0; h < HART_NUM; h++) begin
                mtvec[h]    <= '0;
                mscratch[h] <= '0;
                mepc[h]     <= '0;
                mcause[h]   <= '0;
                minstret[h] <= '0;
            end
        end else begin
            meip <= ext_irq;
            mtip <= timer_irq;

            if ((|csr_hit) && (csr.csr_addr == A_MCYCLE))
                mcycle[31:0] <= new_val;
            else if ((|csr_hit) && (csr.csr_addr == A_MCYCLEH))
                mcycle[CNT_W-1:32] <= new_val[HI_W-1:0];
            else
                mcycle <= mcycle + CNT_W'(1);

            for (int h = 0; h < HART_NUM; h++) begin
                // Sampled from pre-edge state so a trap clears the request one cycle later.
                irq_req[h] <= mie_bit[h] & ((meie[h] & meip[h]) | (mtie[h] & mtip[h]));

                if (trap_hit[h]) begin
                    mepc[h]     <= trap_mepc & ~XLEN'(3);
                    mcause[h]   <= trap_mcause;
                    mpie_bit[h] <= mie_bit[h];
                    mie_bit[h]  <= 1'b0;
                end else if (mret_hit[h]) begin
                    mie_bit[h]  <= mpie_bit[h];
                    mpie_bit[h] <= 1'b1;
                end else if (csr_hit[h]) begin
                    case (csr.csr_addr)
                        A_MSTATUS: begin
                            mie_bit[h]  <= new_val[3];
                            mpie_bit[h] <= new_val[7];
                        end
                        A_MIE: begin
                            meie[h] <= new_val[11];
                            mtie[h] <= new_val[7];
                        end
                        A_MTVEC:    mtvec[h]    <= {new_val[XLEN-1:2],
                                                    new_val[1] ? 2'b00 : new_val[1:0]};
                        A_MSCRATCH: mscratch[h] <= new_val;
                        A_MEPC:     mepc[h]     <= new_val & ~XLEN'(3);
                        A_MCAUSE:   mcause[h]   <= new_val;
                        default:    ;
                    endcase
                end

                if (csr_hit[h] && (csr.csr_addr == A_MINSTRET))
                    minstret[h][31:0] <= new_val;
                else if (csr_hit[h] && (csr.csr_addr == A_MINSTRETH))
                    minstret[h][CNT_W-1:32] <= new_val[HI_W-1:0];
                else if (instret_inc[h])
                    minstret[h] <= minstret[h] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        if (meie[hid] & meip[hid])
            irq_cause_o = 32'h8000_000B;
        else if (mtie[hid] & mtip[hid])
            irq_cause_o = 32'h8000_0007;
        else
            irq_cause_o = '0;
    end

    assign mstatus_o = mstatus_v;
    assign mie_o     = mie_v;
    assign mip_o     = mip_v;
    assign mtvec_o   = mtvec[hid];
    assign mepc_o    = mepc[hid];
    assign mcause_o  = mcause[hid];
endmodule
`default_nettype wire

// File: tb/tb_csr_file_mh.sv
`default_nettype none
// ============================================================================
// Module : tb_csr_file_mh
// Directed bench for csr_file_mh with a word-level reference model.
// Rev    : 1.0
// ============================================================================
module tb_csr_file_mh;
    localparam int HN = 4;
    localparam int HW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [HN-1:0] ext_irq = '0, timer_irq = '0, instret_inc = '0;
    logic          trap_set = 1'b0, mret_set = 1'b0;
    logic [HW-1:0] trap_hart_id = '0, mret_hart_id = '0;
    logic [31:0]   trap_mepc = '0, trap_mcause = '0;
    logic [HN-1:0] irq_req;
    logic [31:0]   irq_cause_o, mstatus_o, mie_o, mip_o, mtvec_o, mepc_o, mcause_o;

    int   n_vec  = 0;
    int   n_fail = 0;
    bit   chk_en = 1'b0;
    logic [31:0] last_rdata;
    logic        last_ill;

    // Reference state, kept as whole architectural words.
    logic [31:0] m_mst [HN], m_mie [HN], m_mip [HN], m_mtvec [HN];
    logic [31:0] m_mscr [HN], m_mepc [HN], m_mcause [HN];
    logic [63:0] m_minst [HN];
    logic [63:0] m_mcyc;
    logic [HN-1:0] m_irq;

    csr_file_mh_if #(.HART_ID_W(HW), .XLEN(32)) bus ();

    csr_file_mh #(.HART_NUM(HN), .HART_ID_W(HW), .XLEN(32), .CNT_W(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .csr          (bus.slave),
        .ext_irq      (ext_irq),
        .timer_irq    (timer_irq),
        .trap_set     (trap_set),
        .trap_hart_id (trap_hart_id),
        .trap_mepc    (trap_mepc),
        .trap_mcause  (trap_mcause),
        .mret_set     (mret_set),
        .mret_hart_id (mret_hart_id),
        .instret_inc  (instret_inc),
        .irq_req      (irq_req),
        .irq_cause_o  (irq_cause_o),
        .mstatus_o    (mstatus_o),
        .mie_o        (mie_o),
        .mip_o        (mip_o),
        .mtvec_o      (mtvec_o),
        .mepc_o       (mepc_o),
        .mcause_o     (mcause_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_ro(input logic [11:0] a);
        return (a == 12'h344) || (a == 12'hF14);
    endfunction

    // {implemented, value}
    function automatic logic [32:0] mread(input int h, input logic [11:0] a);
        logic [32:0] r;
        r = {1'b1, 32'h0};
        case (a)
            12'h300: r[31:0] = m_mst[h];
            12'h304: r[31:0] = m_mie[h];
            12'h305: r[31:0] = m_mtvec[h];
            12'h340: r[31:0] = m_mscr[h];
            12'h341: r[31:0] = m_mepc[h];
            12'h342: r[31:0] = m_mcause[h];
            12'h344: r[31:0] = m_mip[h];
            12'hB00: r[31:0] = m_mcyc[31:0];
            12'hB80: r[31:0] = m_mcyc[63:32];
            12'hB02: r[31:0] = m_minst[h][31:0];
            12'hB82: r[31:0] = m_minst[h][63:32];
            12'hF14: r[31:0] = 32'(h);
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic model_step();
        logic [32:0]   rd;
        logic [31:0]   nv;
        logic [HN-1:0] irqn;
        bit            wr, tr, mr, c, cyc_wr, inst_wr;
        int            hs;
        if (rst) begin
            for (int h = 0; h < HN; h++) begin
                m_mst[h] = 32'h1800; m_mie[h] = '0; m_mip[h] = '0; m_mtvec[h] = '0;
                m_mscr[h] = '0; m_mepc[h] = '0; m_mcause[h] = '0; m_minst[h] = '0;
            end
            m_mcyc = '0;
            m_irq  = '0;
        end else begin
            hs = int'(bus.hart_id);
            rd = mread(hs, bus.csr_addr);
            case (bus.csr_op)
                2'b01:   nv = bus.csr_wdata;
                2'b10:   nv = rd[31:0] | bus.csr_wdata;
                2'b11:   nv = rd[31:0] & ~bus.csr_wdata;
                default: nv = rd[31:0];
            endcase
            wr = (bus.csr_op != 2'b00) && rd[32] && !is_ro(bus.csr_addr);
            for (int h = 0; h < HN; h++)
                irqn[h] = m_mst[h][3] && ((m_mie[h] & m_mip[h]) != 0);
            cyc_wr = 1'b0;
            for (int h = 0; h < HN; h++) begin
                tr = trap_set && (int'(trap_hart_id) == h);
                mr = mret_set && (int'(mret_hart_id) == h) && !tr;
                c  = wr && (hs == h) && !tr && !mr;
                inst_wr = 1'b0;
                if (tr) begin
                    m_mepc[h]   = trap_mepc & 32'hFFFF_FFFC;
                    m_mcause[h] = trap_mcause;
                    m_mst[h]    = 32'h1800 | (m_mst[h][3] ? 32'h80 : 32'h0);
                end else if (mr) begin
                    m_mst[h] = 32'h1880 | (m_mst[h][7] ? 32'h8 : 32'h0);
                end else if (c) begin
                    case (bus.csr_addr)
                        12'h300: m_mst[h]    = 32'h1800 | (nv & 32'h88);
                        12'h304: m_mie[h]    = nv & 32'h880;
                        12'h305: m_mtvec[h]  = (nv[1:0] >= 2'd2) ? (nv & 32'hFFFF_FFFC) : nv;
                        12'h340: m_mscr[h]   = nv;
                        12'h341: m_mepc[h]   = nv & 32'hFFFF_FFFC;
                        12'h342: m_mcause[h] = nv;
                        12'hB00: begin m_mcyc[31:0]  = nv; cyc_wr = 1'b1; end
                        12'hB80: begin m_mcyc[63:32] = nv; cyc_wr = 1'b1; end
                        12'hB02: begin m_minst[h][31:0]  = nv; inst_wr = 1'b1; end
                        12'hB82: begin m_minst[h][63:32] = nv; inst_wr = 1'b1; end
                        default: ;
                    endcase
                end
                if (!inst_wr && instret_inc[h])
                    m_minst[h] = m_minst[h] + 64'd1;
            end
            if (!cyc_wr)
                m_mcyc = m_mcyc + 64'd1;
            for (int h = 0; h < HN; h++)
                m_mip[h] = (ext_irq[h] ? 32'h800 : 32'h0) | (timer_irq[h] ? 32'h80 : 32'h0);
            m_irq = irqn;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial begin : cmp
        int          h;
        logic [32:0] rd;
        logic        exp_ill;
        logic [31:0] exp_cause;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                h  = int'(bus.hart_id);
                rd = mread(h, bus.csr_addr);
                exp_ill = (bus.csr_re || (bus.csr_op != 2'b00))
                        && (!rd[32] || ((bus.csr_op != 2'b00) && is_ro(bus.csr_addr)));
                if ((m_mie[h] & m_mip[h] & 32'h800) != 0)     exp_cause = 32'h8000_000B;
                else if ((m_mie[h] & m_mip[h] & 32'h80) != 0) exp_cause = 32'h8000_0007;
                else                                           exp_cause = 32'h0;
                chk("rdata",       bus.csr_rdata,           rd[31:0]);
                chk("illegal",     32'(bus.csr_illegal),    32'(exp_ill));
                chk("irq_req",     32'(irq_req),            32'(m_irq));
                chk("irq_cause_o", irq_cause_o,             exp_cause);
                chk("mstatus_o",   mstatus_o,               m_mst[h]);
                chk("mie_o",       mie_o,                   m_mie[h]);
                chk("mip_o",       mip_o,                   m_mip[h]);
                chk("mtvec_o",     mtvec_o,                 m_mtvec[h]);
                chk("mepc_o",      mepc_o,                  m_mepc[h]);
                chk("mcause_o",    mcause_o,                m_mcause[h]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input int h, input logic [11:0] a, input logic [1:0] op,
                          input logic [31:0] wd);
        bus.hart_id   = HW'(h);
        bus.csr_addr  = a;
        bus.csr_op    = op;
        bus.csr_wdata = wd;
        bus.csr_re    = 1'b1;
        @(negedge clk);
        last_rdata = bus.csr_rdata;
        last_ill   = bus.csr_illegal;
        tick();
        bus.csr_op = 2'b00;
        bus.csr_re = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.hart_id = '0; bus.csr_addr = '0; bus.csr_op = 2'b00;
        bus.csr_wdata = '0; bus.csr_re = 1'b0;
        tick();
        tick();
        rst    = 1'b0;
        chk_en = 1'b1;

        access(2, 12'h300, 2'b00, 32'h0);
        chk("rst_mstatus", last_rdata, 32'h0000_1800);
        chk("rst_irq_req", 32'(irq_req), 32'h0);
        access(2, 12'hF14, 2'b00, 32'h0);
        chk("mhartid", last_rdata, 32'h2);
        chk("mhartid_ill", 32'(last_ill), 32'h0);

        // External interrupt on hart 1
        access(1, 12'h304, 2'b01, 32'h800);
        access(1, 12'h300, 2'b10, 32'h8);
        ext_irq[1] = 1'b1;
        bus.hart_id = 2'd1;
        tick();
        chk("irq_lat1", 32'(irq_req[1]), 32'h0);
        tick();
        chk("irq_lat2", 32'(irq_req[1]), 32'h1);
        chk("irq_cause", irq_cause_o, 32'h8000_000B);

        // Trap beats a concurrent mepc write on the same hart
        trap_set = 1'b1; trap_hart_id = 2'd1;
        trap_mepc = 32'h1003; trap_mcause = 32'h8000_000B;
        access(1, 12'h341, 2'b01, 32'h55);
        trap_set = 1'b0;
        chk("irq_after_trap", 32'(irq_req[1]), 32'h1);
        access(1, 12'h341, 2'b00, 32'h0);
        chk("trap_mepc", last_rdata, 32'h1000);
        chk("irq_drop", 32'(irq_req[1]), 32'h0);
        access(1, 12'h300, 2'b00, 32'h0);
        chk("trap_mstatus", last_rdata, 32'h1880);
        mret_set = 1'b1; mret_hart_id = 2'd1;
        tick();
        mret_set = 1'b0;
        access(1, 12'h300, 2'b00, 32'h0);
        chk("mret_mstatus", last_rdata, 32'h1888);

        // Independent events on different harts in one cycle
        access(3, 12'h300, 2'b01, 32'h88);
        access(0, 12'h300, 2'b10, 32'h8);
        trap_set = 1'b1; trap_hart_id = 2'd0;
        trap_mepc = 32'h44; trap_mcause = 32'h2;
        access(3, 12'h300, 2'b11, 32'h8);
        trap_set = 1'b0;
        access(3, 12'h300, 2'b00, 32'h0);
        chk("h3_clear", last_rdata, 32'h1880);
        access(0, 12'h300, 2'b00, 32'h0);
        chk("h0_trap_mst", last_rdata, 32'h1880);
        access(0, 12'h341, 2'b00, 32'h0);
        chk("h0_mepc", last_rdata, 32'h44);
        access(0, 12'h342, 2'b00, 32'h0);
        chk("h0_mcause", last_rdata, 32'h2);

        // mtvec WARL and mscratch
        access(2, 12'h305, 2'b01, 32'h2003);
        access(2, 12'h305, 2'b00, 32'h0);
        chk("mtvec_mode3", last_rdata, 32'h2000);
        access(2, 12'h305, 2'b01, 32'h2001);
        access(2, 12'h305, 2'b00, 32'h0);
        chk("mtvec_mode1", last_rdata, 32'h2001);
        access(2, 12'h340, 2'b01, 32'hDEAD_BEEF);
        access(2, 12'h340, 2'b11, 32'h0000_FFFF);
        access(2, 12'h340, 2'b00, 32'h0);
        chk("mscratch", last_rdata, 32'hDEAD_0000);

        // Read-only and unimplemented addresses
        access(1, 12'h344, 2'b01, 32'h0);
        chk("mip_wr_ill", 32'(last_ill), 32'h1);
        access(1, 12'h344, 2'b00, 32'h0);
        chk("mip_kept", last_rdata, 32'h800);
        chk("mip_rd_ill", 32'(last_ill), 32'h0);
        access(0, 12'h7C0, 2'b00, 32'h0);
        chk("unimpl_rd", last_rdata, 32'h0);
        chk("unimpl_ill", 32'(last_ill), 32'h1);
        access(0, 12'hF14, 2'b01, 32'h5);
        chk("mhartid_wr_ill", 32'(last_ill), 32'h1);
        bus.csr_addr = 12'h7C0;
        @(negedge clk);
        chk("idle_ill", 32'(bus.csr_illegal), 32'h0);
        tick();

        // mcycle carry after lo/hi writes
        access(0, 12'hB00, 2'b01, 32'hFFFF_FFFF);
        access(0, 12'hB80, 2'b01, 32'h0);
        tick();
        access(0, 12'hB00, 2'b00, 32'h0);
        chk("mcycle_lo", last_rdata, 32'h0);
        access(0, 12'hB80, 2'b00, 32'h0);
        chk("mcycle_hi", last_rdata, 32'h1);

        // minstret: write wins over a concurrent increment
        instret_inc[2] = 1'b1;
        access(2, 12'hB02, 2'b01, 32'h100);
        instret_inc[2] = 1'b0;
        access(2, 12'hB02, 2'b00, 32'h0);
        chk("minstret_wr", last_rdata, 32'h100);
        instret_inc[2] = 1'b1;
        tick(); tick(); tick();
        instret_inc[2] = 1'b0;
        access(2, 12'hB02, 2'b00, 32'h0);
        chk("minstret_inc", last_rdata, 32'h103);
        access(2, 12'hB82, 2'b01, 32'h5);
        access(2, 12'hB82, 2'b00, 32'h0);
        chk("minstreth", last_rdata, 32'h5);

        // Reset overrides a concurrent trap
        ext_irq = '0;
        trap_set = 1'b1; trap_hart_id = 2'd1; trap_mepc = 32'h500;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        trap_set = 1'b0;
        bus.hart_id = 2'd1;
        @(negedge clk);
        chk("rst_mepc_o", mepc_o, 32'h0);
        chk("rst_mstatus_o", mstatus_o, 32'h1800);
        chk("rst_irq", 32'(irq_req), 32'h0);
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
